// File: rtl/axis_eth_preamble_insert_pkg.sv
// Shared Ethernet line constants and the transmit FSM state encoding
// for the preamble/SFD inserter.
package axis_eth_preamble_insert_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PREAMBLE_LEN  = 7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    PAYLOAD  = 3'd2,
    WAIT_END = 3'd3,
    IFG      = 3'd4
  } state_t;

endpackage

// File: rtl/axis_eth_preamble_insert.sv
// AXI-Stream to GMII egress: prepends preamble and SFD, enforces the
// inter-frame gap and flags mid-frame input underflow with tx_er.
module axis_eth_preamble_insert
  import axis_eth_preamble_insert_pkg::*;
#(
  parameter int IFG_LENGTH = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy,
  output logic       start_packet,
  output logic       error_underflow
);

  localparam logic [7:0] IFG_LAST = 8'(IFG_LENGTH - 1);

  state_t     state, state_n;
  logic [2:0] ptr, ptr_n;
  logic [7:0] ifg_cnt, ifg_cnt_n;
  logic [7:0] txd_n;
  logic       tx_en_n, tx_er_n, start_n, underflow_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      ifg_cnt         <= '0;
      gmii_txd        <= 8'h00;
      gmii_tx_en      <= 1'b0;
      gmii_tx_er      <= 1'b0;
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
    end else begin
      state           <= state_n;
      ptr             <= ptr_n;
      ifg_cnt         <= ifg_cnt_n;
      gmii_txd        <= txd_n;
      gmii_tx_en      <= tx_en_n;
      gmii_tx_er      <= tx_er_n;
      start_packet    <= start_n;
      error_underflow <= underflow_n;
    end
  end

  // Every line output is computed here and registered above, so the line
  // always lags the state decision by exactly one cycle.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    ifg_cnt_n   = ifg_cnt;
    txd_n       = 8'h00;
    tx_en_n     = 1'b0;
    tx_er_n     = 1'b0;
    start_n     = 1'b0;
    underflow_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_axis_tvalid) begin
          txd_n   = PREAMBLE_BYTE;
          tx_en_n = 1'b1;
          start_n = 1'b1;
          ptr_n   = 3'd1;
          state_n = PREAMBLE;
        end
      end
      PREAMBLE: begin
        tx_en_n = 1'b1;
        if (ptr == 3'(PREAMBLE_LEN)) begin
          txd_n   = SFD_BYTE;
          state_n = PAYLOAD;
        end else begin
          txd_n = PREAMBLE_BYTE;
          ptr_n = ptr + 3'd1;
        end
      end
      PAYLOAD: begin
        tx_en_n = 1'b1;
        if (s_axis_tvalid) begin
          txd_n   = s_axis_tdata;
          tx_er_n = s_axis_tlast && s_axis_tuser;
          if (s_axis_tlast) begin
            ifg_cnt_n = '0;
            state_n   = IFG;
          end
        end else begin
          // The line cannot pause mid-frame: poison it and drop the rest.
          tx_er_n     = 1'b1;
          underflow_n = 1'b1;
          state_n     = WAIT_END;
        end
      end
      WAIT_END: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          ifg_cnt_n = '0;
          state_n   = IFG;
        end
      end
      IFG: begin
        ifg_cnt_n = ifg_cnt + 8'd1;
        if (ifg_cnt == IFG_LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign s_axis_tready = (state == PAYLOAD) || (state == WAIT_END);
  assign busy          = (state != IDLE);

endmodule
